uart_tx: RTL

UART transmitter that serialises one byte per frame onto a single line: start bit, 8 data bits LSB first, optional even-parity bit, one stop bit. Bit timing comes from an internal baud counter using the same `BPS_PARA` system-clock-per-bit convention as the team's UART receive path. It sits between a byte producer, connected through a valid/ready handshake, and the board TX pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_bitcnt.sv | 35 +++
 rtl/uart_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, data width, line idle level and
// the default system-clocks-per-bit setting.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned UART_DATA_W   = 8;
    localparam logic        UART_IDLE_LVL = 1'b1;
    localparam int unsigned UART_BPS_PARA = 1250;

endpackage

// File: rtl/uart_tx_bitcnt.sv
// Bit-period counter: counts 0..BPS_PARA-1 while enabled, pulses bit_end on the last count.
// Held at 0 when disabled or cleared.
module uart_tx_bitcnt #(
    parameter int unsigned BPS_PARA = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CNT_W = (BPS_PARA > 1) ? $clog2(BPS_PARA) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_PARA - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || !en || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit (8E1); default build is 8N1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BPS_PARA = UART_BPS_PARA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy
);

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   accept;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign accept   = tx_valid && tx_ready;

    uart_tx_bitcnt #(
        .BPS_PARA (BPS_PARA)
    ) u_bitcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (tx_busy),
        .clr     (accept),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (accept) begin
                    state_d   = ST_START;
                    shreg_d   = tx_data;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = UART_IDLE_LVL;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        // Next data bit is what shreg[0] will hold after this shift.
                        tx_d      = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = UART_IDLE_LVL;
                end
            end
`endif
            ST_STOP: begin
                tx_d = UART_IDLE_LVL;
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = UART_IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
